// File: rtl/data_bus_pkg.sv
// Shared constants and helpers for the CPU data-SRAM responder.
package data_bus_pkg;

  // addr[31:16] value that selects the MMIO window
  localparam logic [15:0] MMIO_BASE_HI_DEFAULT = 16'h1faf;

  // MMIO register offsets (addr[15:0])
  localparam logic [15:0] MMIO_LED     = 16'h0000;
  localparam logic [15:0] MMIO_TIMER   = 16'h0004;
  localparam logic [15:0] MMIO_SWITCH  = 16'h0008;
  localparam logic [15:0] MMIO_SCRATCH = 16'h000C;

  // Merge new_word into old_word on the lanes whose byte enable is set.
  function automatic logic [31:0] apply_be(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/bytewrite_ram.sv
// Word-organised RAM with four byte-lane write enables and a registered
// read port. Contents are not reset; the read register updates only on rd_en.
module bytewrite_ram #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic [3:0]            we,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  // Byte-lane writes and registered read (read sees the pre-write word)
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (rd_en) rdata <= mem[idx];
  end

endmodule

// File: rtl/data_sram_responder.sv
// Responder end of the CPU data-SRAM port: RAM backing store plus a small
// MMIO window (LED, free-running timer, synchronised switches, scratch).
// Handshake: en=1 is a request accepted every cycle (no back-pressure);
// wen!=0 writes at the edge, wen==0 reads and rdata is valid the next cycle
// and holds until the next read.
module data_sram_responder
  import data_bus_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 14,
  parameter logic [15:0] MMIO_BASE_HI = MMIO_BASE_HI_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [15:0] switch_in,
  output logic [15:0] led_out
);

  logic        is_mmio;
  logic        rd_req;
  logic        wr_req;
  logic [15:0] offset;
  logic [3:0]  ram_we;
  logic        ram_rd;
  logic [31:0] ram_q;

  logic [15:0] sw_meta;
  logic [15:0] sw_sync;
  logic [15:0] led_q;
  logic [31:0] timer_q;
  logic [31:0] scratch_q;

  logic [31:0] mmio_rd_val;
  logic [31:0] mmio_q;
  logic        sel_ram;

  assign is_mmio = (addr[31:16] == MMIO_BASE_HI);
  assign offset  = addr[15:0];
  assign rd_req  = en && (wen == 4'b0000);
  assign wr_req  = en && (wen != 4'b0000);

  // Reset also suppresses RAM accesses so nothing lands during reset
  assign ram_we  = (wr_req && !is_mmio && !rst) ? wen : 4'b0000;
  assign ram_rd  = rd_req && !is_mmio && !rst;

  bytewrite_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .rd_en (ram_rd),
    .idx   (addr[ADDR_WIDTH+1:2]),
    .wdata (wdata),
    .rdata (ram_q)
  );

  // Two-flop synchroniser for the asynchronous board switches
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switch_in;
      sw_sync <= sw_meta;
    end
  end

  // MMIO register file; a timer write takes priority over the increment
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q     <= '0;
      timer_q   <= '0;
      scratch_q <= '0;
    end else begin
      if (wr_req && is_mmio && offset == MMIO_TIMER)
        timer_q <= apply_be(timer_q, wdata, wen);
      else
        timer_q <= timer_q + 32'd1;
      if (wr_req && is_mmio && offset == MMIO_LED) begin
        if (wen[0]) led_q[7:0]  <= wdata[7:0];
        if (wen[1]) led_q[15:8] <= wdata[15:8];
      end
      if (wr_req && is_mmio && offset == MMIO_SCRATCH)
        scratch_q <= apply_be(scratch_q, wdata, wen);
    end
  end

  // MMIO read mux; timer returns its value before this edge's increment
  always_comb begin
    mmio_rd_val = 32'h0;
    case (offset)
      MMIO_LED:     mmio_rd_val = {16'h0, led_q};
      MMIO_TIMER:   mmio_rd_val = timer_q;
      MMIO_SWITCH:  mmio_rd_val = {16'h0, sw_sync};
      MMIO_SCRATCH: mmio_rd_val = scratch_q;
      default:      mmio_rd_val = 32'h0;
    endcase
  end

  // Read-source register: selects RAM or captured MMIO data, holds between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_ram <= 1'b0;
      mmio_q  <= '0;
    end else if (rd_req) begin
      sel_ram <= !is_mmio;
      if (is_mmio) mmio_q <= mmio_rd_val;
    end
  end

  assign rdata   = sel_ram ? ram_q : mmio_q;
  assign led_out = led_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: vector table plus hand sequences
// for timer, switch synchroniser and reset-in-flight behaviour.
module tb_data_sram_responder;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [15:0] switch_in;
  logic [15:0] led_out;

  int total;
  int bad;

  logic [31:0] exp_q[$];

  data_sram_responder dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .wen       (wen),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .switch_in (switch_in),
    .led_out   (led_out)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs[21];

  // Driver: apply one access for one clock edge, then settle past the edge
  task automatic step(input logic s_en, input logic [3:0] s_wen,
                      input logic [31:0] s_addr, input logic [31:0] s_wdata);
    en    = s_en;
    wen   = s_wen;
    addr  = s_addr;
    wdata = s_wdata;
    @(posedge clk);
    #1;
    en    = 1'b0;
    wen   = 4'h0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Scoreboard compare against the head of the expected queue
  task automatic check(input string name, input logic [31:0] act);
    logic [31:0] exp;
    exp = exp_q.pop_front();
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  logic [31:0] t0;
  logic [31:0] t1;

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; en = 1'b0; wen = 4'h0; addr = '0; wdata = '0; switch_in = 16'h0;

    vecs[0]  = '{1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 16'h0000};
    vecs[1]  = '{1'b1, 4'h0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 16'h0000};
    vecs[2]  = '{1'b1, 4'h2, 32'h0000_0100, 32'h0000_5500, 32'hDEAD_BEEF, 16'h0000};
    vecs[3]  = '{1'b1, 4'h0, 32'h0000_0100, 32'h0,         32'hDEAD_55EF, 16'h0000};
    vecs[4]  = '{1'b1, 4'h0, 32'h0001_0100, 32'h0,         32'hDEAD_55EF, 16'h0000};
    vecs[5]  = '{1'b1, 4'hF, 32'h1faf_0000, 32'hFFFF_A5A5, 32'hDEAD_55EF, 16'hA5A5};
    vecs[6]  = '{1'b1, 4'h0, 32'h1faf_0000, 32'h0,         32'h0000_A5A5, 16'hA5A5};
    vecs[7]  = '{1'b1, 4'h2, 32'h1faf_0000, 32'h0000_3C00, 32'h0000_A5A5, 16'h3CA5};
    vecs[8]  = '{1'b1, 4'h0, 32'h1faf_0000, 32'h0,         32'h0000_3CA5, 16'h3CA5};
    vecs[9]  = '{1'b1, 4'hF, 32'h1faf_000C, 32'h1234_5678, 32'h0000_3CA5, 16'h3CA5};
    vecs[10] = '{1'b1, 4'h0, 32'h1faf_000C, 32'h0,         32'h1234_5678, 16'h3CA5};
    vecs[11] = '{1'b1, 4'h8, 32'h1faf_000C, 32'hAB00_0000, 32'h1234_5678, 16'h3CA5};
    vecs[12] = '{1'b1, 4'h0, 32'h1faf_000C, 32'h0,         32'hAB34_5678, 16'h3CA5};
    vecs[13] = '{1'b1, 4'hF, 32'h1faf_0010, 32'hFFFF_FFFF, 32'hAB34_5678, 16'h3CA5};
    vecs[14] = '{1'b1, 4'h0, 32'h1faf_0010, 32'h0,         32'h0000_0000, 16'h3CA5};
    vecs[15] = '{1'b1, 4'hF, 32'h0000_0200, 32'h1122_3344, 32'h0000_0000, 16'h3CA5};
    vecs[16] = '{1'b1, 4'h0, 32'h0000_0200, 32'h0,         32'h1122_3344, 16'h3CA5};
    vecs[17] = '{1'b0, 4'hF, 32'h0000_0200, 32'h0,         32'h1122_3344, 16'h3CA5};
    vecs[18] = '{1'b1, 4'h0, 32'h0000_0100, 32'h0,         32'hDEAD_55EF, 16'h3CA5};
    vecs[19] = '{1'b1, 4'h0, 32'h1faf_000C, 32'h0,         32'hAB34_5678, 16'h3CA5};
    vecs[20] = '{1'b1, 4'h0, 32'h0000_0200, 32'h0,         32'h1122_3344, 16'h3CA5};

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back(32'h0); check("reset_rdata", rdata);
    exp_q.push_back(32'h0); check("reset_led", {16'h0, led_out});

    // Vector table
    for (int i = 0; i < 21; i++) begin
      step(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
      exp_q.push_back(vecs[i].exp_rdata);
      check($sformatf("vec%0d_rdata", i), rdata);
      exp_q.push_back({16'h0, vecs[i].exp_led});
      check($sformatf("vec%0d_led", i), {16'h0, led_out});
    end

    // Timer: two reads ten edges apart
    step(1'b1, 4'h0, 32'h1faf_0004, 32'h0);
    t0 = rdata;
    idle(9);
    step(1'b1, 4'h0, 32'h1faf_0004, 32'h0);
    t1 = rdata;
    exp_q.push_back(32'd10); check("timer_delta", t1 - t0);

    // Timer wrap: FFFFFFFE -> FFFFFFFF -> 0, read samples 0
    step(1'b1, 4'hF, 32'h1faf_0004, 32'hFFFF_FFFE);
    idle(2);
    step(1'b1, 4'h0, 32'h1faf_0004, 32'h0);
    exp_q.push_back(32'h0); check("timer_wrap", rdata);

    // Timer partial write: write wins over increment that cycle
    step(1'b1, 4'hF, 32'h1faf_0004, 32'h1234_5678);
    step(1'b1, 4'h1, 32'h1faf_0004, 32'h0000_0000);
    step(1'b1, 4'h0, 32'h1faf_0004, 32'h0);
    exp_q.push_back(32'h1234_5600); check("timer_byte_write", rdata);

    // Switch synchroniser and read-only behaviour
    switch_in = 16'h3C3C;
    idle(3);
    step(1'b1, 4'h0, 32'h1faf_0008, 32'h0);
    exp_q.push_back(32'h0000_3C3C); check("switch_read", rdata);
    step(1'b1, 4'hF, 32'h1faf_0008, 32'hFFFF_FFFF);
    step(1'b1, 4'h0, 32'h1faf_0008, 32'h0);
    exp_q.push_back(32'h0000_3C3C); check("switch_ro", rdata);

    // Reset mid-operation
    step(1'b1, 4'hF, 32'h1faf_0000, 32'h0000_00FF);
    exp_q.push_back(32'h0000_00FF); check("led_pre_reset", {16'h0, led_out});
    step(1'b1, 4'hF, 32'h1faf_0004, 32'h5555_5555);
    rst = 1'b1;
    step(1'b1, 4'h0, 32'h1faf_0004, 32'h0);
    exp_q.push_back(32'h0); check("reset_read_rdata", rdata);
    exp_q.push_back(32'h0); check("reset_led_cleared", {16'h0, led_out});
    step(1'b1, 4'hF, 32'h0000_0100, 32'h0000_0000);
    rst = 1'b0;
    step(1'b1, 4'h0, 32'h1faf_0004, 32'h0);
    exp_q.push_back(32'h0); check("timer_restart", rdata);
    step(1'b1, 4'h0, 32'h0000_0100, 32'h0);
    exp_q.push_back(32'hDEAD_55EF); check("ram_survives_reset", rdata);
    step(1'b1, 4'h0, 32'h1faf_000C, 32'h0);
    exp_q.push_back(32'h0); check("scratch_reset", rdata);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Responder end of the CPU data-SRAM interface: accepts en/wen/addr/wdata from the CPU core and returns rdata.
- Backs a word-organised RAM with byte-lane writes and one-cycle synchronous reads.
- Decodes a small MMIO window holding an LED register, a free-running timer, a switch input and a scratch register.
- Sits in the SoC between the CPU top's data port (physical addresses, post address-translation) and board I/O; it is also the bench's data-memory model.

Parameters:
- ADDR_WIDTH, 14, RAM depth is 2**ADDR_WIDTH words (default 64 KiB).
- MMIO_BASE_HI, 16'h1faf, addr[31:16] value that selects the MMIO window.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  access strobe; no effect when low.
- wen  in  4  byte write enables; 4'b0000 with en=1 means a read.
- addr  in  32  physical byte address; addr[1:0] ignored (word access).
- wdata  in  32  write data; lane i is wdata[8i+7:8i].
- rdata  out  32  read data, valid the cycle after a read.
- switch_in  in  16  board switches, sampled via a 2-flop synchroniser.
- led_out  out  16  LED register contents.

Behaviour:
- Interface contract: one clock; reset is synchronous and active-high; ports named clk and rst.
- Reset values: rdata=0, led_out=0, timer=0, scratch=0, synchroniser flops=0. RAM contents are not reset.
- Region select: if addr[31:16]==MMIO_BASE_HI the access is MMIO; otherwise it is RAM.
- RAM index = addr[ADDR_WIDTH+1:2]. Higher address bits are ignored, so accesses alias/wrap modulo the depth.
- Write (en=1, wen!=0): each lane i with wen[i]=1 updates byte i of the target word/register at this edge. Other lanes are unchanged. rdata holds its previous value.
- Read (en=1, wen=0): rdata is loaded at this edge with the word from that address. Latency is exactly 1 cycle. Back-to-back reads are allowed every cycle.
- Idle (en=0): rdata holds; no state changes except the timer and the synchroniser.
- MMIO offsets (addr[15:0]):
  - 16'h0000 LED: RW; bits [15:0] map to led_out, and bits [31:16] read 0 with writes ignored.
  - 16'h0004 TIMER: RW, 32 bits.
  - 16'h0008 SWITCH: RO; reads {16'h0, synchronised switch_in}, and writes are ignored.
  - 16'h000C SCRATCH: RW, 32 bits.
  - Any other offset reads 0 and ignores writes.
- Timer: increments by 1 every cycle not in reset and wraps 32'hffffffff -> 0.
  - On a TIMER write, written lanes take wdata and unwritten lanes keep the current value; the write wins over the increment for that cycle.
  - A TIMER read returns the value before this edge's increment.
- Read-after-write to the same address on consecutive cycles returns the newly written data (no bypass is needed: the write completes at edge N, the read samples at edge N+1).
- Reset mid-operation: rst has priority over every access. A read issued in the reset cycle yields rdata=0, and a write issued in the reset cycle to an MMIO register is discarded. A RAM write in the reset cycle is also discarded.

Decomposition:
- Shared package data_bus_pkg holds:
  - the MMIO_BASE_HI default;
  - offset constants MMIO_LED=16'h0000, MMIO_TIMER=16'h0004, MMIO_SWITCH=16'h0008, MMIO_SCRATCH=16'h000C;
  - a function applying 4-bit byte enables to a 32-bit old/new word pair.
- One sub-module, bytewrite_ram: ADDR_WIDTH-indexed storage with 4 byte-lane write enables and a registered read port.
- The MMIO registers, timer, synchroniser and rdata mux stay in data_sram_responder.

Test Plan:
- Word write/read: write addr 32'h0000_0100 data 32'hDEADBEEF wen=4'hF, then read the same address -> rdata=32'hDEADBEEF exactly one cycle after the read, and rdata unchanged during the write cycle.
- Byte lanes: from 32'hDEADBEEF, write wen=4'b0010 wdata=32'h0000_5500 -> read returns 32'hDEAD55EF. Read of a wrapped alias (addr + 4<<ADDR_WIDTH) returns the same value.
- LED/SCRATCH: write 32'hFFFF_A5A5 to 32'h1faf_0000 -> led_out=16'hA5A5 next cycle and a read returns 32'h0000_A5A5. SCRATCH write/read of 32'h1234_5678 round-trips; a read of 32'h1faf_0010 returns 0.
- Timer: read TIMER twice 10 cycles apart -> difference 10.
  - Write 32'hFFFF_FFFE with wen=4'hF, then read two cycles later -> 32'h0000_0000 (wrap).
  - Write wen=4'b0001 wdata=8'h00 -> low byte cleared for that cycle and no increment that cycle.
- Switch: drive switch_in=16'h3C3C -> a SWITCH read issued 2 or more cycles later returns 32'h0000_3C3C; a write to SWITCH leaves the read value unchanged.
- Reset mid-operation: after writing LED and TIMER, assert rst in the same cycle as a read of TIMER -> rdata=0, led_out=0, and timer restarts from 0. A RAM word written before reset still reads back its data.
